// File: rtl/clock_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clock_if                                              |
// | Function : control/preset inputs and time outputs of the clock   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface clock_if;
    logic       switch;
    logic [2:0] mode;
    logic [4:0] inhrs;
    logic [5:0] inmin;
    logic [5:0] insec;
    logic [4:0] outhrs;
    logic [5:0] outmin;
    logic [5:0] outsec;

    modport master (
        output switch, mode, inhrs, inmin, insec,
        input  outhrs, outmin, outsec
    );

    modport slave (
        input  switch, mode, inhrs, inmin, insec,
        output outhrs, outmin, outsec
    );
endinterface
`default_nettype wire

// File: rtl/clock.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : clock                                                 |
// | Function : time-of-day clock with 12h view, stopwatch, countdown |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module clock #(
    parameter int TICK_DIV = 100_000_000
) (
    input  wire       clk,
    input  wire       rst_n,
    clock_if.slave    bus
);

    localparam int                  c_cnt_w   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

    localparam logic [2:0] c_mode_24h   = 3'd0;
    localparam logic [2:0] c_mode_12h   = 3'd1;
    localparam logic [2:0] c_mode_stopw = 3'd2;
    localparam logic [2:0] c_mode_down  = 3'd3;

    function automatic logic [4:0] sat_hrs(input logic [4:0] h);
        return (h > 5'd23) ? 5'd23 : h;
    endfunction

    function automatic logic [5:0] sat_ms(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [4:0] to_12h(input logic [4:0] h);
        logic [4:0] res;
        if (h == 5'd0) begin
            res = 5'd12;
        end else if (h > 5'd12) begin
            res = h - 5'd12;
        end else begin
            res = h;
        end
        return res;
    endfunction

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;
    logic [4:0]         r_hrs;
    logic [5:0]         r_min;
    logic [5:0]         r_sec;
    logic [4:0]         r_outhrs;
    logic [5:0]         r_outmin;
    logic [5:0]         r_outsec;

    logic               w_step;
    logic               w_sec_max;
    logic               w_min_max;
    logic               w_sec_zero;
    logic               w_min_zero;
    logic               w_all_zero;
    logic [4:0]         w_inc_hrs;
    logic [5:0]         w_inc_min;
    logic [5:0]         w_inc_sec;
    logic [4:0]         w_dec_hrs;
    logic [5:0]         w_dec_min;
    logic [5:0]         w_dec_sec;
    logic [4:0]         w_hrs_nxt;
    logic [5:0]         w_min_nxt;
    logic [5:0]         w_sec_nxt;

    // Tick is registered so the first step lands a full TICK_DIV cycles
    // after the edge that first samples switch=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (bus.switch) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + c_cnt_one;
            r_tick <= 1'b0;
        end
    end

    assign w_step = r_tick & ~bus.switch;

    always_comb begin
        w_sec_max  = (r_sec == 6'd59);
        w_min_max  = (r_min == 6'd59);
        w_sec_zero = (r_sec == 6'd0);
        w_min_zero = (r_min == 6'd0);
        w_all_zero = w_sec_zero && w_min_zero && (r_hrs == 5'd0);

        w_inc_sec = w_sec_max ? 6'd0 : r_sec + 6'd1;
        w_inc_min = r_min;
        w_inc_hrs = r_hrs;
        if (w_sec_max) begin
            w_inc_min = w_min_max ? 6'd0 : r_min + 6'd1;
            if (w_min_max) begin
                w_inc_hrs = (r_hrs == 5'd23) ? 5'd0 : r_hrs + 5'd1;
            end
        end

        // Only used when the count is non-zero, so hours cannot underflow.
        w_dec_sec = w_sec_zero ? 6'd59 : r_sec - 6'd1;
        w_dec_min = r_min;
        w_dec_hrs = r_hrs;
        if (w_sec_zero) begin
            w_dec_min = w_min_zero ? 6'd59 : r_min - 6'd1;
            if (w_min_zero) begin
                w_dec_hrs = r_hrs - 5'd1;
            end
        end
    end

    always_comb begin
        w_hrs_nxt = r_hrs;
        w_min_nxt = r_min;
        w_sec_nxt = r_sec;
        case (bus.mode)
            c_mode_24h, c_mode_12h: begin
                if (bus.switch) begin
                    w_hrs_nxt = sat_hrs(bus.inhrs);
                    w_min_nxt = sat_ms(bus.inmin);
                    w_sec_nxt = sat_ms(bus.insec);
                end else if (w_step) begin
                    w_hrs_nxt = w_inc_hrs;
                    w_min_nxt = w_inc_min;
                    w_sec_nxt = w_inc_sec;
                end
            end
            c_mode_stopw: begin
                if (bus.switch) begin
                    w_hrs_nxt = 5'd0;
                    w_min_nxt = 6'd0;
                    w_sec_nxt = 6'd0;
                end else if (w_step) begin
                    w_hrs_nxt = w_inc_hrs;
                    w_min_nxt = w_inc_min;
                    w_sec_nxt = w_inc_sec;
                end
            end
            c_mode_down: begin
                if (bus.switch) begin
                    w_hrs_nxt = sat_hrs(bus.inhrs);
                    w_min_nxt = sat_ms(bus.inmin);
                    w_sec_nxt = sat_ms(bus.insec);
                end else if (w_step && !w_all_zero) begin
                    w_hrs_nxt = w_dec_hrs;
                    w_min_nxt = w_dec_min;
                    w_sec_nxt = w_dec_sec;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hrs <= 5'd0;
            r_min <= 6'd0;
            r_sec <= 6'd0;
        end else begin
            r_hrs <= w_hrs_nxt;
            r_min <= w_min_nxt;
            r_sec <= w_sec_nxt;
        end
    end

    // Freeze modes (mode[2] set) hold the displayed value as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outhrs <= 5'd0;
            r_outmin <= 6'd0;
            r_outsec <= 6'd0;
        end else if (!bus.mode[2]) begin
            r_outhrs <= (bus.mode == c_mode_12h) ? to_12h(r_hrs) : r_hrs;
            r_outmin <= r_min;
            r_outsec <= r_sec;
        end
    end

    assign bus.outhrs = r_outhrs;
    assign bus.outmin = r_outmin;
    assign bus.outsec = r_outsec;

endmodule
`default_nettype wire

// File: tb/tb_clock.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_clock                                              |
// | Function : self-checking bench for clock, TICK_DIV = 10          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_clock;

    localparam int c_div = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    clock_if bus ();

    clock #(
        .TICK_DIV(c_div)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    typedef struct {
        logic [2:0] mode;
        hms_t       in;
        hms_t       exp;
    } vec_t;

    hms_t sb_q[$];
    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        sb_q.push_back({h, m, s});
    endtask

    task automatic check(input string name);
        hms_t e;
        hms_t a;
        n_checks++;
        a = {bus.outhrs, bus.outmin, bus.outsec};
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected value queued, got %0d:%0d:%0d", name, a.h, a.m, a.s);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d",
                         name, a.h, a.m, a.s, e.h, e.m, e.s);
            end
        end
    endtask

    task automatic load(input logic [2:0] mode, input logic [4:0] h, input logic [5:0] m,
                        input logic [5:0] s);
        bus.switch = 1'b1;
        bus.mode   = mode;
        bus.inhrs  = h;
        bus.inmin  = m;
        bus.insec  = s;
        step(2);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.switch = 1'b1;
        bus.mode   = 3'd0;
        bus.inhrs  = 5'd7;
        bus.inmin  = 6'd8;
        bus.insec  = 6'd9;

        vecs[0] = '{3'd0, {5'd10, 6'd20, 6'd30}, {5'd10, 6'd20, 6'd30}};
        vecs[1] = '{3'd4, {5'd5,  6'd5,  6'd5 }, {5'd10, 6'd20, 6'd30}};
        vecs[2] = '{3'd1, {5'd13, 6'd5,  6'd0 }, {5'd1,  6'd5,  6'd0 }};
        vecs[3] = '{3'd1, {5'd0,  6'd30, 6'd0 }, {5'd12, 6'd30, 6'd0 }};
        vecs[4] = '{3'd1, {5'd12, 6'd0,  6'd0 }, {5'd12, 6'd0,  6'd0 }};
        vecs[5] = '{3'd1, {5'd23, 6'd59, 6'd59}, {5'd11, 6'd59, 6'd59}};
        vecs[6] = '{3'd0, {5'd24, 6'd60, 6'd60}, {5'd23, 6'd59, 6'd59}};
        vecs[7] = '{3'd2, {5'd5,  6'd5,  6'd5 }, {5'd0,  6'd0,  6'd0 }};
        vecs[8] = '{3'd3, {5'd31, 6'd63, 6'd63}, {5'd23, 6'd59, 6'd59}};
        vecs[9] = '{3'd0, {5'd31, 6'd63, 6'd63}, {5'd23, 6'd59, 6'd59}};

        step(2);
        push_exp(0, 0, 0);
        check("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            push_exp(vecs[i].exp.h, vecs[i].exp.m, vecs[i].exp.s);
            load(vecs[i].mode, vecs[i].in.h, vecs[i].in.m, vecs[i].in.s);
            check($sformatf("vec%0d", i));
        end

        // Saturated preset rolls over on the first tick.
        bus.switch = 1'b0;
        step(c_div + 1);
        push_exp(23, 59, 59);
        check("sat_before_tick");
        step(1);
        push_exp(0, 0, 0);
        check("sat_rollover");

        // 24h roll-over from 23:59:55.
        load(3'd0, 23, 59, 55);
        push_exp(23, 59, 55);
        check("m0_load");
        bus.switch = 1'b0;
        step(c_div + 2);
        push_exp(23, 59, 56);
        check("m0_tick1");
        for (int k = 57; k < 60; k++) begin
            step(c_div);
            push_exp(23, 59, 6'(k));
            check($sformatf("m0_sec%0d", k));
        end
        step(c_div);
        push_exp(0, 0, 0);
        check("m0_wrap");

        // Countdown with borrow, then stop at zero.
        load(3'd3, 0, 1, 1);
        bus.switch = 1'b0;
        step(c_div + 2);
        push_exp(0, 1, 0);
        check("m3_first");
        step(c_div);
        push_exp(0, 0, 59);
        check("m3_borrow");
        load(3'd3, 0, 0, 2);
        bus.switch = 1'b0;
        step(c_div + 2);
        push_exp(0, 0, 1);
        check("m3_one");
        step(c_div);
        push_exp(0, 0, 0);
        check("m3_zero");
        for (int k = 0; k < 5; k++) begin
            step(c_div);
            push_exp(0, 0, 0);
            check($sformatf("m3_hold%0d", k));
        end

        // Stopwatch, then freeze while running.
        load(3'd2, 5, 5, 5);
        push_exp(0, 0, 0);
        check("m2_clear");
        bus.switch = 1'b0;
        step(c_div + 2);
        step(2 * c_div);
        push_exp(0, 0, 3);
        check("m2_three");
        bus.mode = 3'd4;
        for (int k = 0; k < 3; k++) begin
            step(c_div);
            push_exp(0, 0, 3);
            check($sformatf("m4_hold%0d", k));
        end

        // Asynchronous reset mid-second.
        load(3'd0, 12, 34, 55);
        bus.switch = 1'b0;
        step(c_div + 2);
        push_exp(12, 34, 56);
        check("rst_pre");
        step(4);
        #3 rst_n = 1'b0;
        #1;
        push_exp(0, 0, 0);
        check("rst_async");
        step(2);
        push_exp(0, 0, 0);
        check("rst_held");
        rst_n = 1'b1;
        step(c_div + 1);
        push_exp(0, 0, 0);
        check("rst_no_early_tick");
        step(1);
        push_exp(0, 0, 1);
        check("rst_first_tick");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
